// File: rtl/io_pkg.sv
// Shared definitions for the io_debounce block.
//   deb_state_t          : per-channel debounce FSM state (2-bit encoding)
//   SYNC_STAGES_DEF      : default synchroniser depth
//   DEBOUNCE_CYCLES_DEF  : default number of stable samples to accept a level
//   cnt_width()          : width of a counter that must hold 0..n
package io_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } deb_state_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single debounce channel: synchroniser chain, run-length counter, 4-state
// FSM and registered edge pulses.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   din          : raw asynchronous level
//   clean        : debounced level (registered)
//   rise, fall   : one-cycle pulses on clean 0->1 / 1->0 (registered)
//   change_next  : rise|fall as they will be registered on the next edge,
//                  so the parent can register an aligned any_change
module debounce_ch
  import io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic change_next
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  deb_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          clean_next, rise_next, fall_next;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clean_next = clean;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s) begin
          state_next = WAIT_HI;
          cnt_next   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          // counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible
          state_next = STABLE_HI;
          cnt_next   = '0;
          clean_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_next = WAIT_LO;
          cnt_next   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
          clean_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STABLE_LO;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      clean <= clean_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  assign change_next = rise_next | fall_next;

endmodule

// File: rtl/io_debounce.sv
// Multi-channel input debouncer: WIDTH independent debounce_ch instances
// plus a registered any_change flag.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   IO_input    : raw asynchronous levels [WIDTH]
//   IO_clean    : debounced levels [WIDTH]
//   IO_rise     : one-cycle 0->1 pulses [WIDTH]
//   IO_fall     : one-cycle 1->0 pulses [WIDTH]
//   any_change  : one-cycle pulse, OR of all rise/fall pulses in that cycle
module io_debounce
  import io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned WIDTH           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] IO_input,
  output logic [WIDTH-1:0] IO_clean,
  output logic [WIDTH-1:0] IO_rise,
  output logic [WIDTH-1:0] IO_fall,
  output logic             any_change
);

  logic [WIDTH-1:0] change_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .din        (IO_input[i]),
      .clean      (IO_clean[i]),
      .rise       (IO_rise[i]),
      .fall       (IO_fall[i]),
      .change_next(change_next[i])
    );
  end

  // Reduce the channels' next-cycle pulses so any_change lands in the same
  // cycle as the IO_rise/IO_fall bits it summarises.
  always_ff @(posedge clk) begin
    if (reset) any_change <= 1'b0;
    else       any_change <= |change_next;
  end

endmodule

// File: tb/tb_io_debounce.sv
module tb_io_debounce;

  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned W  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] IO_input = '0;
  logic [W-1:0] IO_clean, IO_rise, IO_fall;
  logic         any_change;

  always #50 clk = ~clk;

  io_debounce #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .WIDTH          (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .IO_input  (IO_input),
    .IO_clean  (IO_clean),
    .IO_rise   (IO_rise),
    .IO_fall   (IO_fall),
    .any_change(any_change)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: sync delay line as a queue, acceptance window as a queue
  // of the last DC samples the debouncer has seen since reset.
  logic [W-1:0] syncq[$];
  logic [W-1:0] winq[$];
  logic [W-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
  logic         m_any = 1'b0;

  typedef struct {
    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [W-1:0] din,
                              input logic [W-1:0] clean, input logic [W-1:0] rise,
                              input logic [W-1:0] fall, input logic any);
    vec_t v;
    v.rst = rst; v.din = din; v.clean = clean;
    v.rise = rise; v.fall = fall; v.any = any;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [W-1:0] din);
    logic [W-1:0] s;
    logic         all_opp;
    m_rise = '0;
    m_fall = '0;
    if (rst) begin
      syncq.delete();
      repeat (SS) syncq.push_back('0);
      winq.delete();
      m_clean = '0;
    end else begin
      s = syncq[$];
      void'(syncq.pop_back());
      syncq.push_front(din);
      winq.push_back(s);
      if (winq.size() > DC) void'(winq.pop_front());
      if (winq.size() == DC) begin
        for (int unsigned b = 0; b < W; b++) begin
          all_opp = 1'b1;
          foreach (winq[k]) if (winq[k][b] == m_clean[b]) all_opp = 1'b0;
          if (all_opp) begin
            if (m_clean[b]) m_fall[b] = 1'b1;
            else            m_rise[b] = 1'b1;
            m_clean[b] = ~m_clean[b];
          end
        end
      end
    end
    m_any = |(m_rise | m_fall);
  endtask

  task automatic tick(input logic rst, input logic [W-1:0] din);
    reset    = rst;
    IO_input = din;
    @(posedge clk);
    model_edge(rst, din);
    @(negedge clk);
    check("model", {IO_clean, IO_rise, IO_fall, 3'b0, any_change},
                   {m_clean, m_rise, m_fall, 3'b0, m_any});
    check("rise_fall_excl", {12'b0, IO_rise & IO_fall}, 16'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  seen;
    logic [W-1:0] cur;
    int unsigned first_t, rise_cnt, rise_before;

    repeat (SS) syncq.push_back('0);

    // reset hold, single-bit step, all-bit step, all-bit fall
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    repeat (5) vecs.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'h1, 4'h1, 4'h1, 4'h0, 1));
    vecs.push_back(mk(0, 4'h1, 4'h1, 4'h0, 4'h0, 0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    repeat (5) vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'h0, 1));
    vecs.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0));
    repeat (5) vecs.push_back(mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'hF, 1));
    vecs.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0));

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].din);
      check($sformatf("vec%0d", i),
            {IO_clean, IO_rise, IO_fall, 3'b0, any_change},
            {vecs[i].clean, vecs[i].rise, vecs[i].fall, 3'b0, vecs[i].any});
    end

    // 3-cycle glitch on bit 1 must be swallowed
    tick(1, 4'h0);
    seen = '0;
    repeat (3) begin
      tick(0, 4'b0010);
      seen |= {IO_clean[1], |IO_rise, |IO_fall, any_change};
    end
    repeat (8) begin
      tick(0, 4'h0);
      seen |= {IO_clean[1], |IO_rise, |IO_fall, any_change};
    end
    check("glitch", {12'b0, seen}, 16'h0);

    // reset during the wait on bit 2 abandons it; latency restarts after release
    tick(1, 4'h0);
    rise_before = 0;
    for (int unsigned t = 1; t <= 3; t++) begin
      tick(0, 4'b0100);
      if (IO_rise[2] || IO_clean[2]) rise_before++;
    end
    tick(1, 4'b0100);
    if (IO_rise[2] || IO_clean[2]) rise_before++;
    first_t = 0;
    rise_cnt = 0;
    for (int unsigned t = 1; t <= 10; t++) begin
      tick(0, 4'b0100);
      if (IO_clean[2] && first_t == 0) first_t = t;
      if (IO_rise[2]) rise_cnt++;
    end
    check("rst_no_pulse", 16'(rise_before), 16'd0);
    check("rst_latency", 16'(first_t), 16'(SS + DC));
    check("rst_rise_cnt", 16'(rise_cnt), 16'd1);

    // toggling bit 3 every 2 cycles never settles; holding it high does
    tick(1, 4'h0);
    seen = '0;
    for (int unsigned t = 0; t < 16; t++) begin
      tick(0, ((t / 2) % 2 == 1) ? 4'b1000 : 4'b0000);
      seen |= {IO_clean[3], |IO_rise, |IO_fall, any_change};
    end
    check("toggle", {12'b0, seen}, 16'h0);
    rise_cnt = 0;
    repeat (12) begin
      tick(0, 4'b1000);
      if (IO_rise[3]) rise_cnt++;
    end
    check("toggle_then_hold", {15'b0, IO_clean[3]}, 16'd1);
    check("toggle_rise_cnt", 16'(rise_cnt), 16'd1);

    // randomized run, each bit flips with probability 1/6 per cycle
    cur = '0;
    for (int unsigned n = 0; n < 600; n++) begin
      for (int unsigned b = 0; b < W; b++)
        if ($urandom_range(5) == 0) cur[b] = ~cur[b];
      tick($urandom_range(99) == 0, cur);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/io_debounce.md
IO_DEBOUNCE -- requirements
Module: io_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop synchroniser stages per input bit; legal values 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronised samples required to accept a new level; legal values 2..65535.
REQ-003 Parameter WIDTH, default 4: number of independent input channels.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port IO_input, input, WIDTH: raw, asynchronous switch or pin levels.
REQ-007 Port IO_clean, output, WIDTH: debounced level, fed to the downstream usb block's IO_input.
REQ-008 Port IO_rise, output, WIDTH: one-cycle pulse when the matching IO_clean bit goes 0->1.
REQ-009 Port IO_fall, output, WIDTH: one-cycle pulse when the matching IO_clean bit goes 1->0.
REQ-010 Port any_change, output, 1: one-cycle pulse, equal to the OR of all IO_rise and IO_fall bits.

Function
REQ-011 Each channel SHALL pass its IO_input bit through a SYNC_STAGES-deep flip-flop chain; the last stage is the sample s.
REQ-012 Each channel SHALL run a 4-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-013 STABLE_LO with s=1 SHALL go to WAIT_HI and load the counter with 1; with s=0 it SHALL stay in STABLE_LO.
REQ-014 In WAIT_HI, s=0 SHALL return the FSM to STABLE_LO and clear the counter; IO_clean and the pulse outputs SHALL be unaffected.
REQ-015 In WAIT_HI, s=1 with counter < DEBOUNCE_CYCLES-1 SHALL increment the counter.
REQ-016 In WAIT_HI, s=1 with counter = DEBOUNCE_CYCLES-1 SHALL go to STABLE_HI, set IO_clean=1, and assert IO_rise for exactly that one cycle.
REQ-017 STABLE_HI and WAIT_LO SHALL mirror REQ-013..016 with the polarity inverted; the accepting transition asserts IO_fall.
REQ-018 Latency from the first clk edge that samples a new raw level to the IO_clean change SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles, provided the input stays stable.
REQ-019 A raw pulse or glitch that yields fewer than DEBOUNCE_CYCLES consecutive identical samples SHALL produce no change on IO_clean, IO_rise, IO_fall or any_change.
REQ-020 The counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide and SHALL never wrap; it saturates by construction of REQ-016.
REQ-021 Channels SHALL be fully independent: simultaneous transitions on several channels SHALL produce simultaneous pulses, with any_change asserted once for that cycle.
REQ-022 IO_clean, IO_rise, IO_fall and any_change SHALL all be registered outputs, with no combinational path from IO_input.
REQ-023 IO_rise and IO_fall for the same bit SHALL never be asserted in the same cycle.

Reset
REQ-024 While reset=1 at a clk edge, the SHALL be forced as follows: all synchroniser flops to 0, FSMs to STABLE_LO, counters to 0, IO_clean=0, and IO_rise, IO_fall and any_change to 0.
REQ-025 Reset asserted mid-WAIT SHALL abandon the pending transition; no pulse is emitted, either during or after reset.
REQ-026 After reset is released with IO_input held high, IO_clean SHALL rise SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first non-reset edge, together with an IO_rise pulse.

Structure
REQ-027 A shared package io_pkg SHALL hold the FSM state typedef (2-bit encoding) and the default constants SYNC_STAGES_DEF=2 and DEBOUNCE_CYCLES_DEF=4.
REQ-028 A single-channel sub-module debounce_ch, containing the synchroniser, counter, FSM and pulse logic, SHALL be instantiated WIDTH times in a generate loop.
REQ-029 io_debounce SHALL contain only the generate loop and the any_change OR-reduction register.

Verification (clk period 100 ns, defaults)
REQ-030 Hold reset 2 cycles with IO_input=4'b0000 -> all outputs 0 throughout and after release.
REQ-031 Step IO_input[0] 0->1 and hold -> IO_clean[0]=1 exactly 6 cycles later, with IO_rise[0] and any_change high for that one cycle only.
REQ-032 Pulse IO_input[1] high for 3 cycles, then low -> IO_clean[1] stays 0 and no pulses occur.
REQ-033 Step IO_input from 4'b0000 to 4'b1111 on one edge -> IO_clean=4'b1111 after 6 cycles, IO_rise=4'b1111 for one cycle, and any_change high for one cycle.
REQ-034 Step IO_input[2] high, then assert reset for 1 cycle at cycle 4 -> no IO_rise[2] pulse; IO_clean[2] rises 6 cycles after reset releases.
REQ-035 Toggle IO_input[3] every 2 cycles with DEBOUNCE_CYCLES=4 -> IO_clean[3] stays constant; then hold high -> one IO_rise[3] pulse.
